// File: rtl/instr_encoder_loader.sv
// Packs symbolic instruction fields into 16-bit ISA words and streams them
// into consecutive instruction-memory addresses during a load session.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [1:0]        rn,
  input  logic [1:0]        rm,
  input  logic [1:0]        rx,
  input  logic [1:0]        cmode,
  input  logic [1:0]        shctl,
  input  logic [3:0]        shamt,
  input  logic [8:0]        imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [15:0]         enc_word;
  logic                enc_legal;
  logic                accept;

  // Ready depends only on registered state; the stop cycle is masked
  // internally so a beat coinciding with stop is never taken.
  assign in_ready = (state == S_LOAD) && (word_count < DEPTH_C);
  assign accept   = in_valid && in_ready && !stop;

  // Field packing per instruction format; unused fields are ignored.
  always_comb begin
    enc_word  = 16'h0000;
    enc_legal = 1'b1;
    case (op)
      4'd0: enc_word = {5'b00001, 1'b0, cmode, shctl, rx, rn, rm};
      4'd1: enc_word = {5'b00100, rn, imm};
      4'd2: enc_word = {5'b00101, 1'b0, cmode, shctl, rx, rn, rm};
      4'd3: enc_word = {5'b01000, rn, imm};
      4'd4: enc_word = {5'b01001, 1'b0, cmode, shctl, rx, rn, rm};
      4'd5: enc_word = {5'b01010, 1'b0, cmode, shamt, rn, rm};
      4'd6: enc_word = {5'b01011, 1'b0, cmode, shamt, rn, rm};
      4'd7: enc_word = {5'b01100, 1'b0, 2'b00, 2'b00, 2'b00, rn, rm};
      4'd8: enc_word = {5'b11100, 9'd0, rx};
      default: begin
        enc_word  = 16'h0000;
        enc_legal = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Session sequencing; drain waits for any write still in the output stage.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  if (stop)  state_nx = S_DRAIN;
      S_DRAIN: if (!mem_we) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Write stage, address/word counters, sticky error and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 16'h0000;
      addr_cnt   <= '0;
      word_count <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      busy   <= (state_nx != S_IDLE);
      done   <= (state_nx == S_DONE);
      if (state == S_IDLE && start) begin
        addr_cnt   <= base_addr;
        word_count <= '0;
        err        <= 1'b0;
      end else if (accept) begin
        if (enc_legal) begin
          mem_we     <= 1'b1;
          mem_addr   <= addr_cnt;
          mem_wdata  <= enc_word;
          addr_cnt   <= addr_cnt + ADDR_W'(1);
          word_count <= word_count + CNT_W'(1);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding table, session control,
// depth limit with address wrap, and reset abort.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic        stop;
  logic        in_valid;
  logic [3:0]  op;
  logic [1:0]  rn, rm, rx, cmode, shctl;
  logic [3:0]  shamt;
  logic [8:0]  imm;

  logic        in_ready,  in_ready4;
  logic        mem_we,    mem_we4;
  logic [7:0]  mem_addr,  mem_addr4;
  logic [15:0] mem_wdata, mem_wdata4;
  logic        busy,      busy4;
  logic        done,      done4;
  logic        err,       err4;
  logic [8:0]  word_count, word_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .rn(rn), .rm(rm), .rx(rx),
    .cmode(cmode), .shctl(shctl), .shamt(shamt), .imm(imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .word_count(word_count)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready4), .op(op), .rn(rn), .rm(rm), .rx(rx),
    .cmode(cmode), .shctl(shctl), .shamt(shamt), .imm(imm), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .busy(busy4), .done(done4),
    .err(err4), .word_count(word_count4)
  );

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  rn, rm, rx, cmode, shctl;
    logic [3:0]  shamt;
    logic [8:0]  imm;
    logic        we;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [1:0] n, input logic [1:0] m,
                              input logic [1:0] x, input logic [1:0] c, input logic [1:0] s,
                              input logic [3:0] a, input logic [8:0] i, input logic w,
                              input logic [15:0] d);
    vec_t v;
    v.op = o; v.rn = n; v.rm = m; v.rx = x; v.cmode = c; v.shctl = s;
    v.shamt = a; v.imm = i; v.we = w; v.data = d;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    op = v.op; rn = v.rn; rm = v.rm; rx = v.rx; cmode = v.cmode;
    shctl = v.shctl; shamt = v.shamt; imm = v.imm;
  endtask

  logic [7:0]  exp_addr, last_addr;
  logic [15:0] last_data;
  logic [8:0]  exp_wc;
  logic        exp_err;
  vec_t        v;

  initial begin
    //            op     rn    rm    rx    cm    sh    shamt  imm      we    data
    vecs[0]  = mk(4'd0,  2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 4'd0,  9'h000, 1'b1, 16'h09B6);
    vecs[1]  = mk(4'd1,  2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 4'd7,  9'h1FF, 1'b1, 16'h25FF);
    vecs[2]  = mk(4'd8,  2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 4'd0,  9'h1FF, 1'b1, 16'hE003);
    vecs[3]  = mk(4'd6,  2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 4'd5,  9'h000, 1'b1, 16'h5B51);
    vecs[4]  = mk(4'd7,  2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 4'd0,  9'h000, 1'b1, 16'h600C);
    vecs[5]  = mk(4'd12, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 4'd1,  9'h001, 1'b0, 16'h0000);
    vecs[6]  = mk(4'd2,  2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 4'd0,  9'h000, 1'b1, 16'h2849);
    vecs[7]  = mk(4'd3,  2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0,  9'h0A5, 1'b1, 16'h42A5);
    vecs[8]  = mk(4'd4,  2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 4'd0,  9'h000, 1'b1, 16'h4A13);
    vecs[9]  = mk(4'd5,  2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 4'd15, 9'h000, 1'b1, 16'h50FE);
    vecs[10] = mk(4'd15, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0,  9'h000, 1'b0, 16'h0000);

    reset = 1'b1; start = 1'b0; base_addr = 8'h00; stop = 1'b0; in_valid = 1'b0;
    op = 4'd0; rn = 2'd0; rm = 2'd0; rx = 2'd0; cmode = 2'd0; shctl = 2'd0;
    shamt = 4'd0; imm = 9'd0;
    tick(); tick();
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_wc", 32'(word_count), 32'd0);
    reset = 1'b0;
    tick();

    // Main session: encoding table at base 0x10, back-to-back beats.
    start = 1'b1; base_addr = 8'h10;
    tick();
    start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_in_ready", 32'(in_ready), 32'd1);
    chk("load_err_clear", 32'(err), 32'd0);
    exp_addr = 8'h10; last_addr = 8'h00; last_data = 16'h0000; exp_wc = 9'd0; exp_err = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      if (vecs[i].we) begin
        last_addr = exp_addr; last_data = vecs[i].data;
        exp_addr++; exp_wc++;
      end else begin
        exp_err = 1'b1;
      end
      chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(last_addr));
      chk($sformatf("vec%0d_data", i), 32'(mem_wdata), 32'(last_data));
      chk($sformatf("vec%0d_wc", i), 32'(word_count), 32'(exp_wc));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(exp_err));
    end
    in_valid = 1'b0;
    tick();
    chk("idle_beat_we", 32'(mem_we), 32'd0);

    // Beat coinciding with stop must be dropped; then drain/done/idle.
    v = vecs[0];
    drive(v);
    in_valid = 1'b1; stop = 1'b1;
    tick();
    in_valid = 1'b0; stop = 1'b0;
    chk("stop_beat_we", 32'(mem_we), 32'd0);
    chk("stop_beat_wc", 32'(word_count), 32'(exp_wc));
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_done", 32'(done), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    tick();
    chk("after_done", 32'(done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("err_sticky_idle", 32'(err), 32'd1);

    // Depth-limited session with address wrap on the DEPTH=4 instance.
    start = 1'b1; base_addr = 8'hFE;
    tick();
    start = 1'b0;
    chk("d4_err_cleared", 32'(err), 32'd0);
    chk("d4_wc_cleared", 32'(word_count4), 32'd0);
    exp_addr = 8'hFE;
    for (int i = 0; i < 6; i++) begin
      op = 4'd1; rn = 2'd0; imm = 9'(i);
      in_valid = 1'b1;
      #1;
      chk($sformatf("d4_ready%0d", i), 32'(in_ready4), 32'(i < 4));
      tick();
      chk($sformatf("d4_we%0d", i), 32'(mem_we4), 32'(i < 4));
      if (i < 4) begin
        chk($sformatf("d4_addr%0d", i), 32'(mem_addr4), 32'(exp_addr));
        chk($sformatf("d4_data%0d", i), 32'(mem_wdata4), 32'(16'h2000 | 16'(i)));
        exp_addr++;
      end
    end
    in_valid = 1'b0;
    chk("d4_wc_full", 32'(word_count4), 32'd4);
    chk("d4_ready_full", 32'(in_ready4), 32'd0);
    chk("d4_busy_full", 32'(busy4), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("d4_drain_done", 32'(done4), 32'd0);
    tick();
    chk("d4_done", 32'(done4), 32'd1);
    chk("d4_done_busy", 32'(busy4), 32'd1);
    tick();
    chk("d4_idle_done", 32'(done4), 32'd0);
    chk("d4_idle_busy", 32'(busy4), 32'd0);

    // Reset while a beat is pending aborts the session silently.
    start = 1'b1; base_addr = 8'h40;
    tick();
    start = 1'b0;
    v = vecs[1];
    drive(v);
    in_valid = 1'b1;
    tick();
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_we", 32'(mem_we), 32'd0);
    chk("rst_async_addr", 32'(mem_addr), 32'd0);
    chk("rst_async_data", 32'(mem_wdata), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_wc", 32'(word_count), 32'd0);
    tick();
    chk("rst_hold_we", 32'(mem_we), 32'd0);
    chk("rst_hold_done", 32'(done), 32'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    start = 1'b1; base_addr = 8'h20;
    tick();
    start = 1'b0;
    v = vecs[0];
    drive(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_we", 32'(mem_we), 32'd1);
    chk("post_rst_addr", 32'(mem_addr), 32'h20);
    chk("post_rst_data", 32'(mem_wdata), 32'h09B6);
    chk("post_rst_wc", 32'(word_count), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("post_rst_done", 32'(done), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
